// File: rtl/uart_mmio_pkg.sv
// Shared register map, status bit positions and address decode for the
// UART MMIO responder.
package uart_mmio_pkg;

   localparam logic [31:0] ADDR_TX_STAT = 32'h8000_0000;
   localparam logic [31:0] ADDR_RX_STAT = 32'h8000_0004;
   localparam logic [31:0] ADDR_TX_DATA = 32'h8000_0008;
   localparam logic [31:0] ADDR_RX_DATA = 32'h8000_000C;

   localparam int unsigned TX_NF_BIT  = 0;
   localparam int unsigned TX_OVF_BIT = 1;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_TX_STAT,
      SEL_RX_STAT,
      SEL_TX_DATA,
      SEL_RX_DATA
   } reg_sel_e;

   // Exact 32-bit match; anything else selects nothing.
   function automatic reg_sel_e decode_addr(input logic [31:0] a);
      reg_sel_e sel;
      case (a)
         ADDR_TX_STAT: sel = SEL_TX_STAT;
         ADDR_RX_STAT: sel = SEL_RX_STAT;
         ADDR_TX_DATA: sel = SEL_TX_DATA;
         ADDR_RX_DATA: sel = SEL_RX_DATA;
         default:      sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/uart_mmio_fifo.sv
// Byte FIFO with registered head; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module uart_mmio_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART front end: CPU loads/stores to four registers, with TX
// and RX byte FIFOs between the CPU and the UART transmitter/receiver.
module uart_mmio_responder
   import uart_mmio_pkg::*;
#(
   parameter int unsigned TX_DEPTH = 4,
   parameter int unsigned RX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   reg_sel_e    sel;
   logic        load;
   logic        tx_push, tx_pop, tx_full, tx_empty;
   logic        rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]  tx_head, rx_head;
   logic        tx_ovf_q, tx_ovf_d;
   logic [31:0] rdata_q, rdata_d;
   logic        unused_wdata;

   assign unused_wdata = ^wdata[31:8];

   // Handshake outputs depend only on FIFO state, never on the CPU strobes.
   assign tx_valid = !tx_empty;
   assign tx_data  = tx_head;
   assign rx_ready = !rx_full;
   assign rdata    = rdata_q;

   always_comb begin
      sel     = decode_addr(addr);
      load    = re && !we;
      tx_push = we && (sel == SEL_TX_DATA);
      tx_pop  = !tx_empty && tx_ready;
      rx_push = rx_valid && !rx_full;
      rx_pop  = load && (sel == SEL_RX_DATA) && !rx_empty;

      tx_ovf_d = tx_ovf_q;
      if (load && (sel == SEL_TX_STAT)) begin
         tx_ovf_d = 1'b0;
      end
      if (tx_push && tx_full && !tx_pop) begin
         tx_ovf_d = 1'b1;
      end

      rdata_d = rdata_q;
      if (load) begin
         rdata_d = '0;
         case (sel)
            SEL_TX_STAT: begin
               rdata_d[TX_OVF_BIT] = tx_ovf_q;
               rdata_d[TX_NF_BIT]  = !tx_full;
            end
            SEL_RX_STAT: rdata_d[0]   = !rx_empty;
            SEL_RX_DATA: rdata_d[7:0] = rx_empty ? 8'h00 : rx_head;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_ovf_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         tx_ovf_q <= tx_ovf_d;
         rdata_q  <= rdata_d;
      end
   end

   uart_mmio_fifo #(
      .DEPTH (TX_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (tx_push),
      .pop_i   (tx_pop),
      .wdata_i (wdata[7:0]),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .head_o  (tx_head)
   );

   uart_mmio_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rx_push),
      .pop_i   (rx_pop),
      .wdata_i (rx_data),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .head_o  (rx_head)
   );

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Bench for uart_mmio_responder: directed register-map scenarios followed by
// random traffic, all checked against a queue-based model.
module tb_uart_mmio_responder;

   localparam int TX_DEPTH = 4;
   localparam int RX_DEPTH = 4;
   localparam logic [31:0] A_TXS = 32'h8000_0000;
   localparam logic [31:0] A_RXS = 32'h8000_0004;
   localparam logic [31:0] A_TXD = 32'h8000_0008;
   localparam logic [31:0] A_RXD = 32'h8000_000C;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, wdata, rdata;
   logic        we, re;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready;

   int total = 0;
   int bad   = 0;

   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   bit          m_ovf;
   logic [31:0] m_rdata;
   bit          last_rx_acc;

   uart_mmio_responder #(
      .TX_DEPTH (TX_DEPTH),
      .RX_DEPTH (RX_DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .wdata    (wdata),
      .we       (we),
      .re       (re),
      .rdata    (rdata),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge with inputs set up; checks the handshake
   // outputs, advances the model across the next edge, then checks rdata.
   task automatic step();
      bit         popped, ld, rx_acc, push_tx;
      logic [7:0] b;
      chk("tx_valid", tx_valid, tx_q.size() != 0);
      if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
      chk("rx_ready", rx_ready, rx_q.size() < RX_DEPTH);

      popped  = (tx_q.size() != 0) && tx_ready;
      rx_acc  = rx_valid && (rx_q.size() < RX_DEPTH);
      ld      = re && !we;
      push_tx = 1'b0;

      if (we && addr == A_TXD) begin
         if (tx_q.size() < TX_DEPTH || popped) push_tx = 1'b1;
         else                                  m_ovf   = 1'b1;
      end else if (ld) begin
         case (addr)
            A_TXS: begin
               m_rdata = {30'b0, m_ovf, tx_q.size() < TX_DEPTH};
               m_ovf   = 1'b0;
            end
            A_RXS: m_rdata = {31'b0, rx_q.size() != 0};
            A_RXD: begin
               if (rx_q.size() != 0) begin
                  b       = rx_q.pop_front();
                  m_rdata = {24'b0, b};
               end else begin
                  m_rdata = 32'h0;
               end
            end
            default: m_rdata = 32'h0;
         endcase
      end

      if (popped)  void'(tx_q.pop_front());
      if (push_tx) tx_q.push_back(wdata[7:0]);
      if (rx_acc)  rx_q.push_back(rx_data);
      last_rx_acc = rx_acc;

      @(posedge clk);
      #1;
      chk("rdata", rdata, m_rdata);
   endtask

   task automatic idle();
      we = 1'b0; re = 1'b0;
      step();
   endtask

   task automatic do_store(input logic [31:0] a, input logic [7:0] d);
      we = 1'b1; re = 1'b0; addr = a;
      wdata = $urandom;
      wdata[7:0] = d;
      step();
      we = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a);
      re = 1'b1; we = 1'b0; addr = a;
      step();
      re = 1'b0;
   endtask

   task automatic reset_model();
      tx_q.delete();
      rx_q.delete();
      m_ovf   = 1'b0;
      m_rdata = 32'h0;
   endtask

   initial begin
      logic [7:0] b0;
      int unsigned r;
      rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      last_rx_acc = 1'b0;
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_tx_valid", tx_valid, 1'b0);
      rst_n = 1'b1;
      idle();

      // Two bytes stream out back to back with the sink always ready.
      tx_ready = 1'b1;
      do_store(A_TXD, 8'h41);
      chk("tx_first", tx_data, 8'h41);
      do_store(A_TXD, 8'h42);
      chk("tx_second", tx_data, 8'h42);
      idle();
      chk("tx_drained", tx_valid, 1'b0);

      // Overflow with a stalled sink.
      tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) do_store(A_TXD, 8'(i));
      do_load(A_TXS);
      chk("ovf_status", rdata, 32'h2);
      do_load(A_TXS);
      chk("ovf_cleared", rdata, 32'h0);
      tx_ready = 1'b1;
      repeat (5) idle();

      // RX in order.
      rx_valid = 1'b1; rx_data = 8'hA5; step();
      rx_data = 8'h5A; step();
      rx_valid = 1'b0;
      do_load(A_RXS);  chk("rx_stat_1", rdata, 32'h1);
      do_load(A_RXD);  chk("rx_a5", rdata, 32'hA5);
      do_load(A_RXD);  chk("rx_5a", rdata, 32'h5A);
      do_load(A_RXS);  chk("rx_stat_0", rdata, 32'h0);

      // RX full back-pressure, then a pop frees exactly one slot.
      b0 = 8'($urandom);
      rx_valid = 1'b1; rx_data = b0; step();
      for (int i = 0; i < 3; i++) begin rx_data = 8'($urandom); step(); end
      rx_data = 8'h77;
      idle(); idle();
      chk("rx_full_stall", rx_ready, 1'b0);
      do_load(A_RXD);
      chk("rx_full_pop", rdata, {24'b0, b0});
      chk("rx_ready_back", rx_ready, 1'b1);
      idle();
      rx_valid = 1'b0;
      for (int i = 0; i < 4; i++) do_load(A_RXD);
      chk("rx_77_last", rdata, 32'h77);

      // Empty RX, unmapped address, stores to read-only registers.
      do_load(A_RXD);           chk("rx_empty_load", rdata, 32'h0);
      do_load(A_TXS);           chk("txs_idle", rdata, 32'h1);
      do_load(32'h1234_5678);   chk("unmapped", rdata, 32'h0);
      do_store(A_RXS, 8'hFF);
      do_store(A_TXS, 8'hFF);
      do_load(A_RXS);           chk("rxs_unchanged", rdata, 32'h0);
      do_load(A_TXD);           chk("txd_load", rdata, 32'h0);

      // Store and load in the same cycle: load is ignored, rdata held.
      do_load(A_TXS);
      we = 1'b1; re = 1'b1; addr = A_TXD; wdata = 32'h0000_00C3;
      step();
      we = 1'b0; re = 1'b0;
      chk("we_re_hold", rdata, 32'h1);
      idle();

      // Reset mid-transfer.
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) do_store(A_TXD, 8'($urandom));
      do_load(A_TXS);
      rst_n = 1'b0;
      #1;
      chk("arst_tx_valid", tx_valid, 1'b0);
      chk("arst_rdata", rdata, 32'h0);
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_load(A_TXS);
      chk("post_rst_status", rdata, 32'h1);

      // Random traffic; the RX source holds a byte until it is accepted.
      rx_valid = 1'b0;
      last_rx_acc = 1'b0;
      for (int i = 0; i < 800; i++) begin
         r  = $urandom_range(0, 9);
         we = (r < 3);
         re = (r >= 2) && (r < 6);
         case ($urandom_range(0, 6))
            0:       addr = A_TXS;
            1:       addr = A_RXS;
            2, 3:    addr = A_TXD;
            4:       addr = A_RXD;
            5:       addr = 32'h8000_0010;
            default: addr = $urandom;
         endcase
         wdata = $urandom;
         tx_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 5) == 0);
         if (!rx_valid || last_rx_acc) begin
            rx_valid = ($urandom_range(0, 2) != 0);
            rx_data  = 8'($urandom);
         end
         step();
      end
      we = 1'b0; re = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
      repeat (8) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_mmio_responder.md
UART_MMIO_RESPONDER -- requirements
Module: uart_mmio_responder

Interface
REQ-001 Parameter TX_DEPTH, default 4, TX FIFO entries (power of 2, >=2).
REQ-002 Parameter RX_DEPTH, default 4, RX FIFO entries (power of 2, >=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 addr  input  32  CPU data address, sampled when we or re high.
REQ-006 wdata  input  32  CPU store data; only [7:0] used.
REQ-007 we  input  1  CPU store strobe, one cycle per store.
REQ-008 re  input  1  CPU load strobe, one cycle per load.
REQ-009 rdata  output  32  registered load data.
REQ-010 tx_data  output  8  byte to UART transmitter.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  transmitter accepts byte when tx_valid & tx_ready.
REQ-013 rx_data  input  8  byte from UART receiver.
REQ-014 rx_valid  input  1  rx_data valid.
REQ-015 rx_ready  output  1  responder accepts byte when rx_valid & rx_ready.

Function
REQ-016 Exact 32-bit address decode; map: 0x80000000 TX status, 0x80000004 RX status, 0x80000008 TX data (store), 0x8000000C RX data (load).
REQ-017 Load 0x80000000 returns {30'b0, tx_ovf, tx_not_full}; the load clears tx_ovf.
REQ-018 Load 0x80000004 returns {31'b0, rx_not_empty}.
REQ-019 Load 0x8000000C returns {24'b0, RX head} and pops RX FIFO; if empty returns 0, no pop, no state change.
REQ-020 Load of any other address (incl. 0x80000008) returns 0.
REQ-021 Load latency one cycle: re at edge N -> rdata valid after edge N, held until next re.
REQ-022 Store to 0x80000008 pushes wdata[7:0] into TX FIFO if not full or if a TX pop occurs the same cycle.
REQ-023 Store to full TX FIFO with no same-cycle pop: byte dropped, tx_ovf set (sticky).
REQ-024 Stores to other addresses ignored; stores to status/RX addresses have no effect.
REQ-025 we and re high same cycle: store performed, load ignored, rdata held.
REQ-026 tx_valid = TX FIFO non-empty; tx_data = TX head, driven from registers; store at edge N -> tx_valid high after edge N.
REQ-027 TX pop on tx_valid & tx_ready; tx_data/tx_valid stable while tx_valid & !tx_ready.
REQ-028 rx_ready = RX FIFO not full; push on rx_valid & rx_ready; no RX data ever lost.
REQ-029 RX simultaneous push and pop (load 0x8000000C) when full: rx_ready low, pop only; count decrements.
REQ-030 Pointers wrap modulo depth; counts range 0..DEPTH, full at DEPTH.
REQ-031 tx_ovf set and cleared same cycle: set wins.
REQ-032 FIFO order strictly first-in first-out on both paths.

Reset
REQ-033 rst_n low: both FIFOs empty, pointers/counts 0, tx_ovf 0, rdata 0, tx_valid 0, rx_ready 1 after deassert.
REQ-034 Reset mid-transfer discards all queued bytes; tx_valid drops asynchronously.

Structure
REQ-035 Address constants (four register addresses) and bit positions of tx_ovf/tx_not_full in shared package uart_mmio_pkg.
REQ-036 One sub-module uart_mmio_fifo (parameterised depth, width 8, push/pop/full/empty/head), instantiated twice.
REQ-037 No combinational path from addr/we/re to tx_valid, tx_data or rx_ready.

Verification
REQ-038 Store 0x41,0x42 to 0x80000008, tx_ready=1 -> tx_data 0x41 then 0x42 on consecutive cycles, tx_valid low after.
REQ-039 tx_ready=0, five stores 0x01..0x05 -> first four queued, tx_ovf=1; load 0x80000000 -> rdata 0x2; next load -> 0x0 (full).
REQ-040 Drive rx bytes 0xA5,0x5A; load 0x80000004 -> 1; two loads 0x8000000C -> 0xA5, 0x5A; load 0x80000004 -> 0.
REQ-041 Fill RX with 4 bytes, rx_valid held with 0x77 -> rx_ready=0; one RX-data load -> rx_ready=1, 0x77 accepted, order intact.
REQ-042 Load 0x8000000C on empty RX -> rdata 0; load 0x12345678 -> rdata 0; store to 0x80000004 -> no state change.
REQ-043 Assert rst_n low with 3 TX bytes queued and tx_ready=0 -> tx_valid 0 immediately, rdata 0, status 0x80000000 reads 0x1 after release.
